// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcodes and ALU-control classes.
package mips_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        ADDIEX = 4'd11,
        ADDIWB = 4'd12,
        HALT   = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Every return to FETCH is diverted to HALT while an interrupt is pending.
    function automatic state_e fetch_or_halt(input logic interrupt);
        return interrupt ? HALT : FETCH;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: Moore datapath controls, memory wait timeout and interrupt halt.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       interrupt,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memtoReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic [3:0] state,
    output logic       halted,
    output logic       illegalOp,
    output logic       memTimeout
);

    localparam int unsigned CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             waiting;
    logic             timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state, memory wait tracking and error pulses.
    always_comb begin
        state_d   = state_q;
        waiting   = 1'b0;
        timeout   = 1'b0;
        illegalOp = 1'b0;
        unique case (state_q)
            IDLE:   state_d = fetch_or_halt(interrupt);
            FETCH:  if (memReady) state_d = DECODE; else waiting = 1'b1;
            DECODE: begin
                unique case (opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default: begin
                        state_d   = fetch_or_halt(interrupt);
                        illegalOp = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (memReady) state_d = MEMWB; else waiting = 1'b1;
            MEMWR:  if (memReady) state_d = fetch_or_halt(interrupt); else waiting = 1'b1;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: state_d = fetch_or_halt(interrupt);
            HALT:   if (!interrupt) state_d = FETCH;
            default: state_d = IDLE;
        endcase
        // A stalled access that has already waited WAIT_LIMIT cycles is abandoned.
        if (waiting && (wait_q == CNT_MAX)) begin
            timeout = 1'b1;
            state_d = fetch_or_halt(interrupt);
        end
        wait_d     = (waiting && !timeout) ? wait_q + CNT_W'(1) : '0;
        memTimeout = timeout;
    end

    // Moore control decode; only the FETCH write strobes follow memReady.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memtoReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = ALUOP_ADD;
        pcSource    = 2'b00;
        halted      = 1'b0;
        unique case (state_q)
            FETCH: begin
                memRead = 1'b1;
                irWrite = memReady;
                pcWrite = memReady;
                aluSrcB = 2'b01;
            end
            DECODE: aluSrcB = 2'b11;
            MEMADR, ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            MEMWB: begin
                memtoReg = 1'b1;
                regWrite = 1'b1;
            end
            MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = ALUOP_SUB;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            ADDIWB: regWrite = 1'b1;
            HALT:   halted   = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected state/controls queued and checked.
module tb_multicycle_control;

    logic       clock, reset, interrupt, memReady;
    logic [5:0] opcode;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memtoReg, regDst, regWrite, aluSrcA, halted, illegalOp, memTimeout;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;

    typedef struct packed {
        logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
        logic       memto_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       halted, illegal_op, mem_timeout;
    } ctrl_t;

    typedef struct {
        logic [3:0] st;
        ctrl_t      ctrl;
        string      tag;
    } exp_t;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7;
    localparam logic [3:0] S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDIEX = 4'd11;
    localparam logic [3:0] S_ADDIWB = 4'd12, S_HALT = 4'd13;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, ILL = 6'b111111;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    ctrl_t got_ctrl;

    multicycle_control #(.WAIT_LIMIT(15)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .interrupt(interrupt),
        .memReady(memReady), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .memtoReg(memtoReg),
        .regDst(regDst), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .aluOp(aluOp), .pcSource(pcSource), .state(state), .halted(halted),
        .illegalOp(illegalOp), .memTimeout(memTimeout)
    );

    assign got_ctrl = '{pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg,
                        regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, halted,
                        illegalOp, memTimeout};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Control table written straight from the state descriptions.
    function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr,
                                       input logic ill, input logic to);
        ctrl_t c = '0;
        case (st)
            S_FETCH:  begin c.mem_read = 1; c.ir_write = mr; c.pc_write = mr; c.alu_src_b = 2'b01; end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.mem_read = 1; c.ior_d = 1; end
            S_MEMWB:  begin c.memto_reg = 1; c.reg_write = 1; end
            S_MEMWR:  begin c.mem_write = 1; c.ior_d = 1; end
            S_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            S_ALUWB:  begin c.reg_dst = 1; c.reg_write = 1; end
            S_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            S_JUMP:   begin c.pc_write = 1; c.pc_source = 2'b10; end
            S_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_ADDIWB: c.reg_write = 1;
            S_HALT:   c.halted = 1;
            default:  ;
        endcase
        c.illegal_op  = ill;
        c.mem_timeout = to;
        return c;
    endfunction

    task automatic check_front();
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        assert (state === e.st) else begin
            n_bad++;
            $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
        end
        n_cmp++;
        assert (got_ctrl === e.ctrl) else begin
            n_bad++;
            $error("FAIL %s ctrl: got %b expected %b", e.tag, got_ctrl, e.ctrl);
        end
    endtask

    task automatic expect_now(input logic [3:0] st, input logic ill, input logic to,
                              input string tag);
        exp_t e;
        e.st   = st;
        e.ctrl = exp_ctrl(st, memReady, ill, to);
        e.tag  = tag;
        sb.push_back(e);
        #1;
        check_front();
    endtask

    task automatic step(input logic [5:0] op, input logic mr, input logic intr,
                        input logic [3:0] st, input logic ill, input logic to,
                        input string tag);
        @(negedge clock);
        opcode    = op;
        memReady  = mr;
        interrupt = intr;
        expect_now(st, ill, to, tag);
    endtask

    initial begin
        reset = 1'b1; opcode = R; memReady = 1'b0; interrupt = 1'b0;
        expect_now(S_IDLE, 0, 0, "reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        expect_now(S_IDLE, 0, 0, "idle");

        step(R, 1, 0, S_FETCH,  0, 0, "r_fetch");
        step(R, 1, 0, S_DECODE, 0, 0, "r_decode");
        step(R, 1, 0, S_EXEC,   0, 0, "r_exec");
        step(R, 1, 0, S_ALUWB,  0, 0, "r_aluwb");

        step(LW, 1, 0, S_FETCH,  0, 0, "lw_fetch");
        step(LW, 1, 0, S_DECODE, 0, 0, "lw_decode");
        step(LW, 1, 0, S_MEMADR, 0, 0, "lw_memadr");
        for (int i = 0; i < 3; i++) step(LW, 0, 0, S_MEMRD, 0, 0, "lw_memrd_wait");
        step(LW, 1, 0, S_MEMRD,  0, 0, "lw_memrd_done");
        step(LW, 1, 0, S_MEMWB,  0, 0, "lw_memwb");

        step(BEQ, 1, 0, S_FETCH,  0, 0, "beq_fetch");
        step(BEQ, 1, 0, S_DECODE, 0, 0, "beq_decode");
        step(BEQ, 1, 0, S_BRANCH, 0, 0, "beq_branch");

        step(J, 1, 0, S_FETCH,  0, 0, "j_fetch");
        step(J, 1, 0, S_DECODE, 0, 0, "j_decode");
        step(J, 1, 0, S_JUMP,   0, 0, "j_jump");

        step(ADDI, 1, 0, S_FETCH,  0, 0, "addi_fetch");
        step(ADDI, 1, 0, S_DECODE, 0, 0, "addi_decode");
        step(ADDI, 1, 0, S_ADDIEX, 0, 0, "addi_ex");
        step(ADDI, 1, 0, S_ADDIWB, 0, 0, "addi_wb");

        // sw stalls: 15 tolerated wait cycles, timeout on the 16th
        step(SW, 1, 0, S_FETCH,  0, 0, "sw_fetch");
        step(SW, 1, 0, S_DECODE, 0, 0, "sw_decode");
        step(SW, 1, 0, S_MEMADR, 0, 0, "sw_memadr");
        for (int i = 0; i < 15; i++) step(SW, 0, 0, S_MEMWR, 0, 0, "sw_memwr_wait");
        step(SW, 0, 0, S_MEMWR, 0, 1, "sw_timeout");

        // re-fetch stalls to the limit, memReady on the limit cycle wins
        for (int i = 0; i < 15; i++) step(SW, 0, 0, S_FETCH, 0, 0, "refetch_wait");
        step(SW, 1, 0, S_FETCH,  0, 0, "refetch_ready_at_limit");
        step(SW, 1, 0, S_DECODE, 0, 0, "sw2_decode");
        step(SW, 1, 0, S_MEMADR, 0, 0, "sw2_memadr");
        step(SW, 1, 0, S_MEMWR,  0, 0, "sw2_memwr");

        step(R, 1, 0, S_FETCH,  0, 0, "int_fetch");
        step(R, 1, 0, S_DECODE, 0, 0, "int_decode");
        step(R, 1, 1, S_EXEC,   0, 0, "int_exec");
        step(R, 1, 1, S_ALUWB,  0, 0, "int_aluwb");
        step(R, 1, 1, S_HALT,   0, 0, "int_halt");
        step(R, 1, 1, S_HALT,   0, 0, "int_halt_hold");
        step(R, 1, 0, S_HALT,   0, 0, "int_halt_release");

        step(ILL, 1, 0, S_FETCH,  0, 0, "ill_fetch");
        step(ILL, 1, 0, S_DECODE, 1, 0, "ill_decode");

        step(SW, 1, 0, S_FETCH,  0, 0, "rst_fetch");
        step(SW, 1, 0, S_DECODE, 0, 0, "rst_decode");
        step(SW, 1, 0, S_MEMADR, 0, 0, "rst_memadr");
        step(SW, 0, 0, S_MEMWR,  0, 0, "rst_memwr");
        #1 reset = 1'b1;
        expect_now(S_IDLE, 0, 0, "async_reset_mid_memwr");
        @(negedge clock);
        reset = 1'b0;
        expect_now(S_IDLE, 0, 0, "idle_after_reset");
        step(R, 1, 0, S_FETCH, 0, 0, "fetch_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
